// File: rtl/convolutional_unit.sv
// D x D MAC array: per-column kernel buffers, per-row neuron buffers, registered column sums.
// Latency: accumulators update on mac; partialSumOut is registered one edge after the latch command.
// Backpressure: none; every control is acted on in the cycle it is presented.
module convolutional_unit #(
    parameter int depth = 2,
    parameter int A     = 7,
    parameter int W     = 16,
    localparam int D    = 2**depth
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [W*D-1:0]         partialSumIn,
    output logic [W*D-1:0]         partialSumOut,
    input  logic [W*D-1:0]         kBuffIn,
    input  logic [W*D-1:0]         nBuffIn,
    input  logic [D*8-1:0]         columnControl,
    input  logic [D-1:0]           rowControl,
    input  logic [3*depth+2*A-1:0] commonControl
);

    logic [depth-1:0] tc, tr, shift;
    logic [A-1:0]     kernel_step, neuron_step;

    assign {tc, tr, kernel_step, neuron_step, shift} = commonControl;

    logic [D-1:0] k_wr, k_clr, mac, acc_clr, psum_add, out_latch, n_clr_col;
    logic         n_clr, any_mac;

    always_comb begin
        for (int c = 0; c < D; c++) begin
            k_wr[c]      = columnControl[8*c+0];
            k_clr[c]     = columnControl[8*c+1];
            mac[c]       = columnControl[8*c+2];
            acc_clr[c]   = columnControl[8*c+3];
            psum_add[c]  = columnControl[8*c+4];
            out_latch[c] = columnControl[8*c+5];
            n_clr_col[c] = columnControl[8*c+6];
        end
    end

    assign n_clr   = |n_clr_col;
    assign any_mac = |mac;

    logic [W-1:0] kmem [D][2**A];
    logic [W-1:0] nmem [D][2**A];
    logic [A-1:0] kwp [D];
    logic [A-1:0] krp [D];
    logic [A-1:0] nwp [D];
    logic [A-1:0] nrp [D];

    logic [W-1:0] kv [D];
    logic [W-1:0] nv [D];
    logic [W-1:0] acc [D][D];
    logic [W-1:0] term [D][D];
    logic         active [D][D];
    logic [W-1:0] col_sum [D];

    logic signed [2*W-1:0] prod, prod_sh;

    always_comb begin
        prod    = '0;
        prod_sh = '0;
        for (int c = 0; c < D; c++) kv[c] = kmem[c][krp[c]];
        for (int r = 0; r < D; r++) nv[r] = nmem[r][nrp[r]];
        for (int r = 0; r < D; r++) begin
            for (int c = 0; c < D; c++) begin
                active[r][c] = (r <= int'(tr)) && (c <= int'(tc));
                // Sign-extend both operands so the 2W-bit product is the exact signed result.
                prod    = {{W{kv[c][W-1]}}, kv[c]} * {{W{nv[r][W-1]}}, nv[r]};
                prod_sh = prod >>> shift;
                term[r][c] = prod_sh[W-1:0];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < D; c++) begin
            col_sum[c] = psum_add[c] ? partialSumIn[W*c +: W] : '0;
            for (int r = 0; r < D; r++) col_sum[c] = col_sum[c] + acc[r][c];
        end
    end

    // Buffer contents carry no reset; only the pointers do.
    always_ff @(posedge CLK) begin
        for (int c = 0; c < D; c++)
            if (k_wr[c] && !k_clr[c]) kmem[c][kwp[c]] <= kBuffIn[W*c +: W];
        for (int r = 0; r < D; r++)
            if (rowControl[r] && !n_clr) nmem[r][nwp[r]] <= nBuffIn[W*r +: W];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < D; i++) begin
                kwp[i] <= '0;
                krp[i] <= '0;
                nwp[i] <= '0;
                nrp[i] <= '0;
                for (int j = 0; j < D; j++) acc[i][j] <= '0;
            end
            partialSumOut <= '0;
        end else begin
            for (int c = 0; c < D; c++) begin
                if (k_clr[c]) begin
                    kwp[c] <= '0;
                    krp[c] <= '0;
                end else begin
                    if (k_wr[c]) kwp[c] <= kwp[c] + A'(1);
                    if (mac[c])  krp[c] <= krp[c] + kernel_step;
                end
            end
            for (int r = 0; r < D; r++) begin
                if (n_clr) begin
                    nwp[r] <= '0;
                    nrp[r] <= '0;
                end else begin
                    if (rowControl[r]) nwp[r] <= nwp[r] + A'(1);
                    if (any_mac)       nrp[r] <= nrp[r] + neuron_step;
                end
            end
            for (int r = 0; r < D; r++) begin
                for (int c = 0; c < D; c++) begin
                    if (!active[r][c] || acc_clr[c]) acc[r][c] <= '0;
                    else if (mac[c])                 acc[r][c] <= acc[r][c] + term[r][c];
                end
            end
            for (int c = 0; c < D; c++)
                if (out_latch[c]) partialSumOut[W*c +: W] <= col_sum[c];
        end
    end

endmodule

// File: tb/tb_convolutional_unit.sv
// Randomized and directed bench for convolutional_unit against a transaction-level reference model.
module tb_convolutional_unit;
    localparam int DEPTH = 2;
    localparam int D     = 4;
    localparam int A     = 7;
    localparam int W     = 16;
    localparam int NW    = 128;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic [W*D-1:0]   partialSumIn = '0;
    logic [W*D-1:0]   partialSumOut;
    logic [W*D-1:0]   kBuffIn = '0;
    logic [W*D-1:0]   nBuffIn = '0;
    logic [D*8-1:0]   columnControl = '0;
    logic [D-1:0]     rowControl = '0;
    logic [19:0]      commonControl = '0;

    convolutional_unit #(.depth(DEPTH), .A(A), .W(W)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .partialSumIn(partialSumIn), .partialSumOut(partialSumOut),
        .kBuffIn(kBuffIn), .nBuffIn(nBuffIn),
        .columnControl(columnControl), .rowControl(rowControl),
        .commonControl(commonControl)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model state
    logic [W-1:0] mk [D][NW];
    logic [W-1:0] mn [D][NW];
    logic [6:0]   kwp [D];
    logic [6:0]   krp [D];
    logic [6:0]   nwp [D];
    logic [6:0]   nrp [D];
    logic [W-1:0] macc [D][D];
    logic [W-1:0] mout [D];

    task automatic model_reset();
        for (int i = 0; i < D; i++) begin
            kwp[i] = 0; krp[i] = 0; nwp[i] = 0; nrp[i] = 0; mout[i] = 0;
            for (int j = 0; j < D; j++) macc[i][j] = 0;
        end
    endtask

    task automatic model_edge(input logic [31:0] cc, input logic [3:0] rc, input logic [19:0] cm,
                              input logic [63:0] kin, input logic [63:0] nin, input logic [63:0] ps);
        logic [1:0] tc, tr, sh;
        logic [6:0] ks, ns;
        logic [7:0] b;
        logic nclr, anymac;
        logic [W-1:0] s;
        logic [W-1:0] kv [D];
        logic [W-1:0] nv [D];
        int p;
        {tc, tr, ks, ns, sh} = cm;
        nclr = 0; anymac = 0;
        for (int c = 0; c < D; c++) begin
            b = cc[8*c +: 8];
            nclr |= b[6];
            anymac |= b[2];
            kv[c] = mk[c][krp[c]];
        end
        for (int r = 0; r < D; r++) nv[r] = mn[r][nrp[r]];
        for (int c = 0; c < D; c++) begin
            b = cc[8*c +: 8];
            if (b[5]) begin
                s = b[4] ? ps[W*c +: W] : 16'h0;
                for (int r = 0; r < D; r++) s += macc[r][c];
                mout[c] = s;
            end
        end
        for (int r = 0; r < D; r++)
            for (int c = 0; c < D; c++) begin
                b = cc[8*c +: 8];
                if (r > tr || c > tc || b[3]) macc[r][c] = 0;
                else if (b[2]) begin
                    p = int'($signed(kv[c])) * int'($signed(nv[r]));
                    p = p >>> sh;
                    macc[r][c] += p[W-1:0];
                end
            end
        for (int c = 0; c < D; c++) begin
            b = cc[8*c +: 8];
            if (b[1]) begin
                kwp[c] = 0; krp[c] = 0;
            end else begin
                if (b[0]) begin mk[c][kwp[c]] = kin[W*c +: W]; kwp[c]++; end
                if (b[2]) krp[c] += ks;
            end
        end
        for (int r = 0; r < D; r++) begin
            if (nclr) begin
                nwp[r] = 0; nrp[r] = 0;
            end else begin
                if (rc[r]) begin mn[r][nwp[r]] = nin[W*r +: W]; nwp[r]++; end
                if (anymac) nrp[r] += ns;
            end
        end
    endtask

    task automatic cyc(input logic [31:0] cc, input logic [3:0] rc, input logic [19:0] cm,
                       input logic [63:0] kin, input logic [63:0] nin, input logic [63:0] ps);
        @(negedge CLK);
        columnControl = cc; rowControl = rc; commonControl = cm;
        kBuffIn = kin; nBuffIn = nin; partialSumIn = ps;
        @(posedge CLK);
        model_edge(cc, rc, cm, kin, nin, ps);
        #1;
        for (int c = 0; c < D; c++) check($sformatf("out%0d", c), partialSumOut[W*c +: W], mout[c]);
    endtask

    function automatic logic [19:0] cmn(input int tc, input int tr, input int ks, input int ns, input int sh);
        return {2'(tc), 2'(tr), 7'(ks), 7'(ns), 2'(sh)};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    localparam logic [31:0] ALL_CLR   = 32'h42020202;
    localparam logic [31:0] ALL_ACCLR = 32'h08080808;

    initial begin
        logic [19:0] c0;
        logic [31:0] cc;
        c0 = cmn(3, 3, 1, 1, 0);
        #1;
        for (int c = 0; c < D; c++) check($sformatf("rst%0d", c), partialSumOut[W*c +: W], 16'h0);
        model_reset();
        #11 RST_N = 1'b1;

        for (int i = 0; i < NW; i++) cyc(32'h01010101, 4'hF, c0, rnd64(), rnd64(), 64'h0);

        // partial-sum passthrough
        cyc(ALL_ACCLR, 4'h0, c0, 64'h0, 64'h0, 64'h0);
        cyc(32'h30303030, 4'h0, c0, 64'h0, 64'h0, {4{16'h0001}});
        for (int c = 0; c < D; c++) check($sformatf("pass%0d", c), partialSumOut[W*c +: W], 16'h0001);

        // single MAC
        cyc(ALL_CLR, 4'h0, c0, 64'h0, 64'h0, 64'h0);
        cyc(32'h01, 4'hF, c0, 64'h3, 64'h5, 64'h0);
        cyc(ALL_ACCLR, 4'h0, c0, 64'h0, 64'h0, 64'h0);
        cyc(32'h04, 4'h0, c0, 64'h0, 64'h0, 64'h0);
        cyc(32'h20, 4'h0, c0, 64'h0, 64'h0, 64'h0);
        check("mac_single", partialSumOut[15:0], 16'h000F);

        // signed product with arithmetic shift
        cyc(ALL_CLR, 4'h0, c0, 64'h0, 64'h0, 64'h0);
        cyc(32'h01, 4'hF, c0, 64'hFFFC, 64'h8, 64'h0);
        cyc(ALL_ACCLR, 4'h0, c0, 64'h0, 64'h0, 64'h0);
        cyc(32'h04, 4'h0, cmn(3, 3, 1, 1, 2), 64'h0, 64'h0, 64'h0);
        cyc(32'h20, 4'h0, c0, 64'h0, 64'h0, 64'h0);
        check("mac_shift", partialSumOut[15:0], 16'hFFF8);

        // tile masking: Tr=0, Tc=0
        cyc(ALL_CLR, 4'h0, c0, 64'h0, 64'h0, 64'h0);
        cyc(32'h0101, 4'hF, c0, {16'h0, 16'h0, 16'h3, 16'h3}, {4{16'h0005}}, 64'h0);
        cyc(ALL_ACCLR, 4'h0, c0, 64'h0, 64'h0, 64'h0);
        cyc(32'h0404, 4'h0, cmn(0, 0, 1, 1, 0), 64'h0, 64'h0, 64'h0);
        cyc(32'h2020, 4'h0, cmn(0, 0, 1, 1, 0), 64'h0, 64'h0, 64'h0);
        check("mask_row", partialSumOut[15:0], 16'h000F);
        check("mask_col", partialSumOut[31:16], 16'h0000);

        // kernel stepping by 2
        cyc(ALL_CLR, 4'h0, c0, 64'h0, 64'h0, 64'h0);
        for (int i = 0; i < 6; i++)
            cyc(32'h01, (i == 0) ? 4'hF : 4'h0, c0, 64'(i + 1), 64'h1, 64'h0);
        cyc(ALL_ACCLR, 4'h0, c0, 64'h0, 64'h0, 64'h0);
        for (int i = 0; i < 3; i++) cyc(32'h04, 4'h0, cmn(3, 3, 2, 0, 0), 64'h0, 64'h0, 64'h0);
        cyc(32'h20, 4'h0, c0, 64'h0, 64'h0, 64'h0);
        check("step_sum", partialSumOut[15:0], 16'd9);

        // read pointer 126 + 2 wraps to 0
        cyc(32'h02, 4'h0, c0, 64'h0, 64'h0, 64'h0);
        cyc(32'h04, 4'h0, cmn(3, 3, 126, 0, 0), 64'h0, 64'h0, 64'h0);
        cyc(32'h04, 4'h0, cmn(3, 3, 2, 0, 0), 64'h0, 64'h0, 64'h0);
        cyc(32'h08, 4'h0, c0, 64'h0, 64'h0, 64'h0);
        cyc(32'h04, 4'h0, cmn(3, 3, 1, 0, 0), 64'h0, 64'h0, 64'h0);
        cyc(32'h20, 4'h0, c0, 64'h0, 64'h0, 64'h0);
        check("wrap", partialSumOut[15:0], 16'h0001);

        // asynchronous reset with nonzero outputs, no clock edge
        @(negedge CLK);
        columnControl = '0; rowControl = '0;
        #2 RST_N = 1'b0;
        #1;
        for (int c = 0; c < D; c++) check($sformatf("arst%0d", c), partialSumOut[W*c +: W], 16'h0);
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        cyc(32'h0, 4'h0, c0, 64'h0, 64'h0, 64'h0);

        for (int i = 0; i < 500; i++) begin
            cc = $urandom;
            if ($urandom_range(0, 7) != 0) cc &= ~32'h40404040;
            if ($urandom_range(0, 3) != 0) cc &= ~32'h02020202;
            cyc(cc, 4'($urandom), 20'($urandom), rnd64(), rnd64(), rnd64());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/convolutional_unit.md
CONVOLUTIONAL_UNIT -- requirements
Module: convolutional_unit

Interface
REQ-001 SHALL have parameters: depth, default 2, log2 of array size; D = 2^depth, derived, rows = columns = D; A, default 7, local buffer address width; W, default 16, data word width.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port partialSumIn, input, W*D, incoming partial sums; word c is bits [W*c+W-1:W*c].
REQ-005 SHALL have port partialSumOut, output, W*D, registered column results; word c belongs to column c.
REQ-006 SHALL have port kBuffIn, input, W*D, kernel write data; word c goes to column c.
REQ-007 SHALL have port nBuffIn, input, W*D, neuron write data; word r goes to row r.
REQ-008 SHALL have port columnControl, input, D*8, byte c controls column c: bit0 kWr, bit1 kClr, bit2 mac, bit3 accClr, bit4 psumAdd, bit5 outLatch, bit6 nClr, bit7 reserved and ignored.
REQ-009 SHALL have port rowControl, input, D, bit r is nWr for row r.
REQ-010 SHALL have port commonControl, input, 3*depth+2*A, packed MSB to LSB as {Tc[depth], Tr[depth], kernelStep[A], neuronStep[A], shift[depth]}.

Function
REQ-011 SHALL contain one kernel memory per column, KMEM_c, with 2^A words of W bits, a write pointer kwp_c and a read pointer krp_c.
REQ-012 SHALL contain one neuron memory per row, NMEM_r, with 2^A words of W bits, a write pointer nwp_r and a read pointer nrp_r.
REQ-013 SHALL handle kWr_c as: KMEM_c[kwp_c] <= kBuffIn word c, then kwp_c += 1.
REQ-014 SHALL handle nWr_r as: NMEM_r[nwp_r] <= nBuffIn word r, then nwp_r += 1.
REQ-015 SHALL handle kClr_c as: kwp_c and krp_c <= 0; kClr wins over kWr in the same cycle and the write is dropped.
REQ-016 SHALL handle nClr: the OR of bit6 over all column bytes clears nwp and nrp of every row; nClr wins over nWr and the write is dropped.
REQ-017 SHALL apply A-bit modulo-2^A wrap to all pointer arithmetic.
REQ-018 SHALL read memories combinationally at the read pointers: kv_c = KMEM_c[krp_c] and nv_r = NMEM_r[nrp_r].
REQ-019 SHALL define PE(r,c) as active when r <= Tr and c <= Tc; an inactive PE SHALL hold its accumulator at 0.
REQ-020 SHALL update the accumulator of each active PE(r,c) on mac_c: acc <= acc + trunc_W((kv_c * nv_r) >>> shift), using a signed 2W-bit product, arithmetic right shift and two's-complement wrap.
REQ-021 SHALL advance krp_c by kernelStep in every cycle mac_c=1.
REQ-022 SHALL advance every nrp_r by neuronStep in every cycle where any mac_c=1.
REQ-023 SHALL clear acc(r,c) to 0 for all r when accClr_c=1; accClr takes priority over mac_c.
REQ-024 SHALL form the column sum S_c = sum over r of acc(r,c), plus partialSumIn word c when psumAdd_c=1, with W-bit wrapping arithmetic.
REQ-025 SHALL latch S_c into partialSumOut word c on outLatch_c, using acc values from before the same edge; otherwise the output word holds its value.
REQ-026 SHALL give one-cycle latency from accumulator update to visible output, i.e. a mac at edge n, then an outLatch at edge n+1, makes the value visible after edge n+1.
REQ-027 SHALL keep columns independent; controls of one column never affect another, except nClr and the mac-driven nrp advance.

Reset
REQ-028 SHALL, while RST_N=0 and regardless of CLK, force every accumulator, every pointer and partialSumOut to 0.
REQ-029 SHALL NOT reset memory contents; reads of unwritten locations are undefined.
REQ-030 SHALL resume normal operation at the first rising CLK edge after RST_N rises.

Verification (D=4, W=16, A=7)
REQ-031 SHALL cover reset: drive RST_N=0 mid-operation with nonzero outputs -> partialSumOut=0 immediately, with no clock edge.
REQ-032 SHALL cover partial-sum passthrough: accClr all columns, then psumAdd+outLatch all columns with partialSumIn words=0x0001 -> every output word=0x0001 after one edge.
REQ-033 SHALL cover a single MAC: Tr=Tc=3, shift=0; write K=3 to column 0; write N=5 to row 0 and N=0 to rows 1-3; one mac on column 0; then outLatch -> word0=0x000F.
REQ-034 SHALL cover shift with signed values: K=0xFFFC (-4), N=8, shift=2 -> word0=0xFFF8 (-8).
REQ-035 SHALL cover tile masking: Tr=0 with N=5 in all rows, K=3, one mac -> word0=0x000F rather than 0x003C; with Tc=0, column 1 output stays 0.
REQ-036 SHALL cover stepping and wrap: kernelStep=2 with KMEM_0 = {1,2,3,4,...} and N=1, three macs -> sum 1+3+5=9; krp set to 126 with step 2 wraps to 0.
